ram_param_clr: RTL
==================

// Module: ram_param_clr
// PURPOSE
//  Parametrised single-port synchronous RAM, successor to the fixed 16-bit RAM16K.
//  Adds configurable width/depth, a registered read with a valid flag, and a
//  hardware clear engine that zeroes every word after reset or on request.
//  Sits under the CPU data-memory decode in place of fixed-size RAM blocks.
// PARAMETERS
//  WIDTH   16     data word width in bits
//  AWIDTH  14     address width in bits
//  DEPTH   16384  number of words; must satisfy 1 <= DEPTH <= 2**AWIDTH
// PORTS
//  clock      in   1       rising-edge clock
//  reset_n    in   1       asynchronous active-low reset
//  in         in   WIDTH   write data
//  load       in   1       write enable, sampled on rising clock
//  address    in   AWIDTH  word address for read and write
//  clear      in   1       request full-memory clear, sampled on rising clock
//  out        out  WIDTH   registered read data
//  out_valid  out  1       out holds data read at previous edge's address
//  busy       out  1       clear engine running; accesses ignored
//  addr_err   out  1       previous-cycle address was >= DEPTH
//  parity_err out  1       previous-cycle read failed parity check
// BEHAVIOUR
//  - Reset (reset_n=0, async): out=0, out_valid=0, addr_err=0, parity_err=0,
//    busy=1, clear counter=0, FSM=CLR. Memory array contents not reset directly.
//  - FSM states: CLR, IDLE.
//    CLR: each edge writes 0 to mem[cnt], cnt++; at cnt==DEPTH-1 write it,
//    go IDLE next edge. Clear takes exactly DEPTH cycles; busy=1 throughout,
//    falls to 0 on the edge that enters IDLE.
//    IDLE: clear=1 -> CLR with cnt=0, busy=1 from next edge; load/read that
//    same edge is still serviced normally.
//  - While busy: load ignored; out=0, out_valid=0, addr_err=0, parity_err=0.
//  - IDLE access, per edge: if address<DEPTH and load=1 then mem[address]<=in.
//    out<=mem[address] (read latency 1 cycle); out_valid<=1.
//  - Read-during-write same address: write-first, out takes the new in.
//  - address>=DEPTH: write dropped, out<=0, out_valid<=1, addr_err<=1.
//  - Reset asserted mid-clear or mid-access: immediately returns to reset
//    values; clear restarts from word 0 when reset_n rises.
//  - clear asserted while already busy: ignored (no restart).
// CONFIGURATION
//  RAM_PARITY_EN defined: each word stores WIDTH+1 bits, extra bit = ^in
//    (clear writes parity 0 for all-zero word). On IDLE read of an in-range
//    address, parity_err<=(^stored_data != stored_parity); out still
//    returns stored data.
//  RAM_PARITY_EN undefined: WIDTH-bit storage only; parity_err tied 0.
// TESTING (DEPTH=16, AWIDTH=5, WIDTH=16 unless noted)
//  1 reset_n low 3 cycles then high -> busy=1 for exactly 16 edges, then 0;
//    reads of addr 0..15 return 0 with out_valid=1.
//  2 load=1 in=3 addr=5 one edge; load=0 addr=5 -> out=3 one edge later,
//    addr 4 and 6 still read 0.
//  3 load=1 in=16'hBEEF addr=7 -> same-edge read gives out=16'hBEEF (write-first).
//  4 load=1 in=9 addr=20 -> addr_err=1, out=0; read addr 20-16=4 still 0.
//  5 write addr 2=55, pulse clear, drop reset_n at clear cycle 6, release ->
//    full 16-cycle clear, addr 2 reads 0; load during busy has no effect.
//  6 RAM_PARITY_EN: write addr 1=16'h0001, bench flips stored data bit 3 by
//    hierarchical deposit -> read addr 1 gives parity_err=1; addr 0 gives 0.

Source files
------------

// File: rtl/ram_param_clr.sv
// ram_param_clr: parametrised single-port synchronous RAM with a registered
// read, valid flag, address-range error flag and a hardware clear engine
// that zeroes every word after reset or on request.
// Optional feature macro: RAM_PARITY_EN. When it is defined, each word carries
// an extra even-parity bit that is checked on every in-range read.
module ram_param_clr #(
  parameter int WIDTH  = 16,
  parameter int AWIDTH = 14,
  parameter int DEPTH  = 16384
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [AWIDTH-1:0] address,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic              busy,
  output logic              addr_err,
  output logic              parity_err
);

  // Index width actually needed to address DEPTH words.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef RAM_PARITY_EN
  localparam int SW = WIDTH + 1;  // stored word: {parity, data}
`else
  localparam int SW = WIDTH;
`endif
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  typedef enum logic {
    CLR  = 1'b0,
    IDLE = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              valid_q, valid_d;
  logic              aerr_q, aerr_d;
`ifdef RAM_PARITY_EN
  logic              perr_q, perr_d;
`endif

  logic [SW-1:0]     mem_q [DEPTH];
  logic              we;
  logic [IW-1:0]     waddr;
  logic [SW-1:0]     wdata;
  logic              in_range;
  logic [IW-1:0]     idx;
  logic [SW-1:0]     rd_word;
  logic [SW-1:0]     in_word;

  assign in_range = ({1'b0, address} < (AWIDTH + 1)'(DEPTH));
  assign idx      = address[IW-1:0];
  assign rd_word  = mem_q[idx];
`ifdef RAM_PARITY_EN
  assign in_word  = {^in, in};
`else
  assign in_word  = in;
`endif

  // Next-state, write-port and read-result decode for the CLR/IDLE engine.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = '0;
    valid_d = 1'b0;
    aerr_d  = 1'b0;
`ifdef RAM_PARITY_EN
    perr_d  = 1'b0;
`endif
    we      = 1'b0;
    waddr   = idx;
    wdata   = in_word;
    case (state_q)
      CLR: begin
        // Sweep every word to zero, one per edge; the parity of zero is zero.
        we    = 1'b1;
        waddr = cnt_q;
        wdata = '0;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        valid_d = 1'b1;
        if (in_range) begin
          we = load;
          // Write-first: a same-edge read of the written word returns new data.
          out_d = load ? in : rd_word[WIDTH-1:0];
`ifdef RAM_PARITY_EN
          perr_d = !load && ((^rd_word[WIDTH-1:0]) != rd_word[WIDTH]);
`endif
        end else begin
          aerr_d = 1'b1;
        end
        // The access on this edge is still serviced; clearing starts next.
        if (clear) begin
          state_d = CLR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLR;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and output registers; reset restarts the clear sweep from word 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLR;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      aerr_q  <= 1'b0;
`ifdef RAM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      aerr_q  <= aerr_d;
`ifdef RAM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Storage array write port.
  always_ff @(posedge clock) begin
    // NOTE: the array has no reset branch so it maps onto RAM macros; the
    // clear engine is what zeroes it. Writes are held off while in reset.
    if (reset_n && we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign addr_err  = aerr_q;
  assign busy      = (state_q == CLR);
`ifdef RAM_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
